// File: rtl/memory_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_stage_pkg
// Description : Shared definitions for the memory access pipeline stage:
//               funct3 load/store encodings, access-size codes, writeback
//               select encodings and the stage FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_access_stage_pkg;

  // Load encodings (funct3)
  localparam logic [2:0] c_f3_lb  = 3'b000;
  localparam logic [2:0] c_f3_lh  = 3'b001;
  localparam logic [2:0] c_f3_lw  = 3'b010;
  localparam logic [2:0] c_f3_lbu = 3'b100;
  localparam logic [2:0] c_f3_lhu = 3'b101;

  // Store encodings (funct3)
  localparam logic [2:0] c_f3_sb  = 3'b000;
  localparam logic [2:0] c_f3_sh  = 3'b001;
  localparam logic [2:0] c_f3_sw  = 3'b010;

  // Access size lives in funct3[1:0] for both loads and stores
  localparam logic [1:0] c_size_byte = 2'b00;
  localparam logic [1:0] c_size_half = 2'b01;
  localparam logic [1:0] c_size_word = 2'b10;

  // Writeback select (dmem_to_reg); 2'b11 falls back to the ALU result
  localparam logic [1:0] c_wb_alu = 2'b00;
  localparam logic [1:0] c_wb_mem = 2'b01;
  localparam logic [1:0] c_wb_pc4 = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  function automatic logic [1:0] access_size(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_access_stage_load_store_align.sv
`default_nettype none
// ============================================================================
// Module      : load_store_align
// Description : Combinational lane logic for the memory stage: byte enables,
//               store data replication and load byte/halfword extraction with
//               sign or zero extension. The lane logic assumes four byte
//               lanes (XLEN = 32).
// Ports       : i_funct3      - access size/sign
//               i_offset      - byte address bits [1:0]
//               i_store_data  - raw store operand
//               i_rdata       - raw memory read word
//               o_be          - byte enables
//               o_wdata       - replicated store data
//               o_load_data   - extracted and extended load value
//               o_misaligned  - access violates natural alignment
// Config      : MEM_MISALIGN_TRAP_EN - when defined, misaligned halfword/word
//               accesses are flagged; otherwise low offset bits are masked to
//               the access size and o_misaligned is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_align
  import memory_access_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_offset,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [XLEN-1:0] i_rdata,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_load_data,
  output logic            o_misaligned
);

  logic [1:0]  w_size;
  logic [1:0]  w_off;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_size = access_size(i_funct3);

`ifdef MEM_MISALIGN_TRAP_EN
    w_off = i_offset;
    case (w_size)
      c_size_byte: o_misaligned = 1'b0;
      c_size_half: o_misaligned = i_offset[0];
      default:     o_misaligned = (i_offset != 2'b00);
    endcase
`else
    o_misaligned = 1'b0;
    case (w_size)
      c_size_byte: w_off = i_offset;
      c_size_half: w_off = {i_offset[1], 1'b0};
      default:     w_off = 2'b00;
    endcase
`endif

    case (w_size)
      c_size_byte: begin
        o_be    = 4'b0001 << w_off;
        o_wdata = {(XLEN/8){i_store_data[7:0]}};
      end
      c_size_half: begin
        o_be    = 4'b0011 << w_off;
        o_wdata = {(XLEN/16){i_store_data[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_store_data;
      end
    endcase

    // Halfword lane uses only offset bit 1 so the slice stays in range even
    // for an odd (trapped) address.
    w_byte = i_rdata[{w_off, 3'b000} +: 8];
    w_half = i_rdata[{w_off[1], 4'b0000} +: 16];

    case (i_funct3)
      c_f3_lb:  o_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      c_f3_lh:  o_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      c_f3_lbu: o_load_data = {{(XLEN-8){1'b0}}, w_byte};
      c_f3_lhu: o_load_data = {{(XLEN-16){1'b0}}, w_half};
      default:  o_load_data = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_stage
// Description : MEM pipeline stage. Issues data-memory requests for loads and
//               stores, stalls upstream while memory is not ready, and
//               registers the writeback value into the MEM/WB outputs one
//               cycle after the operation completes.
// Ports       : clk_i, reset_i          - clock, synchronous active-high reset
//               em_*                    - EX/MEM pipeline register inputs
//               dmem_*                  - data memory request/response
//               mem_stall_o             - freeze upstream stages
//               mw_*                    - MEM/WB register outputs
//               misalign_o              - misaligned access pulse (optional)
// Config      : MEM_MISALIGN_TRAP_EN - adds misalign_o and suppresses
//               misaligned halfword/word accesses instead of masking the
//               address.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            em_reg_write_i,
  input  logic            em_mem_read_i,
  input  logic            em_mem_write_i,
  input  logic [1:0]      em_dmem_to_reg_i,
  input  logic [4:0]      em_write_addr_reg_i,
  input  logic [2:0]      em_funct3_i,
  input  logic [XLEN-1:0] em_alu_result_i,
  input  logic [XLEN-1:0] em_read_data2_i,
  input  logic [XLEN-1:0] em_pc_plus4_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_ready_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            mem_stall_o,
  output logic            mw_valid_o,
  output logic            mw_reg_write_o,
  output logic [4:0]      mw_write_addr_reg_o,
  output logic [XLEN-1:0] mw_write_data_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            misalign_o
`endif
);

  mem_state_e r_state;
  mem_state_e w_state_next;

  // Latched EX/MEM copy, used while waiting on memory
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;
  logic [1:0]      r_dmem_to_reg;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_pc4;

  // MEM/WB register
  logic            r_mw_valid;
  logic            r_mw_reg_write;
  logic [4:0]      r_mw_rd;
  logic [XLEN-1:0] r_mw_data;

  // Operation currently being served: live inputs in IDLE, latched in WAIT
  logic            w_reg_write;
  logic            w_mem_read;
  logic            w_mem_write;
  logic [1:0]      w_dmem_to_reg;
  logic [4:0]      w_rd;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_rs2;
  logic [XLEN-1:0] w_pc4;

  logic            w_mem_op;
  logic            w_mis_raw;
  logic            w_misaligned;
  logic            w_issue;
  logic            w_complete;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_wb_data;

  always_comb begin
    if (r_state == WAIT) begin
      w_reg_write   = r_reg_write;
      w_mem_read    = r_mem_read;
      w_mem_write   = r_mem_write;
      w_dmem_to_reg = r_dmem_to_reg;
      w_rd          = r_rd;
      w_funct3      = r_funct3;
      w_alu         = r_alu;
      w_rs2         = r_rs2;
      w_pc4         = r_pc4;
    end else begin
      w_reg_write   = em_reg_write_i;
      w_mem_read    = em_mem_read_i;
      w_mem_write   = em_mem_write_i;
      w_dmem_to_reg = em_dmem_to_reg_i;
      w_rd          = em_write_addr_reg_i;
      w_funct3      = em_funct3_i;
      w_alu         = em_alu_result_i;
      w_rs2         = em_read_data2_i;
      w_pc4         = em_pc_plus4_i;
    end
  end

  load_store_align #(
    .XLEN (XLEN)
  ) u_align (
    .i_funct3     (w_funct3),
    .i_offset     (w_alu[1:0]),
    .i_store_data (w_rs2),
    .i_rdata      (dmem_rdata_i),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data),
    .o_misaligned (w_mis_raw)
  );

  // Next-state and output logic
  always_comb begin
    w_state_next = IDLE;
    w_mem_op     = w_mem_read | w_mem_write;
    w_misaligned = w_mem_op & w_mis_raw;
    // Reset gates the request and stall immediately, not only at the edge
    w_issue      = w_mem_op & ~w_misaligned & ~reset_i;
    // Non-memory and trapped ops retire at once; memory ops wait for ready
    w_complete   = ~reset_i & (~w_mem_op | w_misaligned | dmem_ready_i);

    dmem_req_o   = w_issue;
    dmem_we_o    = w_issue & w_mem_write;   // write wins over read
    dmem_addr_o  = {w_alu[XLEN-1:2], 2'b00};
    dmem_be_o    = w_be;
    dmem_wdata_o = w_wdata;
    mem_stall_o  = w_issue & ~dmem_ready_i;

    if (w_issue && !dmem_ready_i) begin
      w_state_next = WAIT;
    end

    case (w_dmem_to_reg)
      c_wb_mem: w_wb_data = w_load_data;
      c_wb_pc4: w_wb_data = w_pc4;
      default:  w_wb_data = w_alu;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state        <= IDLE;
      r_reg_write    <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_dmem_to_reg  <= '0;
      r_rd           <= '0;
      r_funct3       <= '0;
      r_alu          <= '0;
      r_rs2          <= '0;
      r_pc4          <= '0;
      r_mw_valid     <= 1'b0;
      r_mw_reg_write <= 1'b0;
      r_mw_rd        <= '0;
      r_mw_data      <= '0;
    end else begin
      r_state <= w_state_next;
      // Capture every IDLE cycle; the copy only matters once WAIT is entered
      if (r_state == IDLE) begin
        r_reg_write   <= em_reg_write_i;
        r_mem_read    <= em_mem_read_i;
        r_mem_write   <= em_mem_write_i;
        r_dmem_to_reg <= em_dmem_to_reg_i;
        r_rd          <= em_write_addr_reg_i;
        r_funct3      <= em_funct3_i;
        r_alu         <= em_alu_result_i;
        r_rs2         <= em_read_data2_i;
        r_pc4         <= em_pc_plus4_i;
      end
      r_mw_valid     <= w_complete;
      r_mw_reg_write <= w_complete & w_reg_write & ~w_misaligned;
      if (w_complete) begin
        r_mw_rd   <= w_rd;
        r_mw_data <= w_wb_data;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_complete & w_misaligned;
    end
  end

  assign misalign_o = r_misalign;
`endif

  assign mw_valid_o          = r_mw_valid;
  assign mw_reg_write_o      = r_mw_reg_write;
  assign mw_write_addr_reg_o = r_mw_rd;
  assign mw_write_data_o     = r_mw_data;

endmodule
`default_nettype wire
